operand_wkup_buf: RTL and testbench

Single-entry operand capture buffer between an issue queue and its execution unit. Latches operands and per-operand wake-up hit vectors on issue, merges late wake-up data broadcast on the following cycle, and holds the merged operands under downstream back-pressure with a valid/ready handshake. It is a parametrised successor to the one-cycle wake-up data stage, adding reset, stall-safe holding, a sideband payload, flush and handshake semantics.

---
 rtl/operand_wkup_buf_pkg.sv | 20 ++
 rtl/operand_wkup_buf_if.sv | 36 +++
 rtl/operand_wkup_buf_wkup_merge.sv | 56 +++++
 rtl/operand_wkup_buf.sv | 113 +++++++++++
 tb/tb_operand_wkup_buf.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/operand_wkup_buf_pkg.sv
`default_nettype none
// =============================================================================
// Module   : operand_wkup_buf_pkg
// Brief    : Shared types for the operand wake-up capture buffer.
// Revision : 1.0
// =============================================================================
package operand_wkup_buf_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;

    typedef logic [DEF_DATA_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FRESH = 2'd1,
        HELD  = 2'd2
    } buf_state_e;

endpackage : operand_wkup_buf_pkg
`default_nettype wire

// File: rtl/operand_wkup_buf_if.sv
`default_nettype none
// =============================================================================
// Module   : operand_wkup_buf_if
// Brief    : Issue-side / execute-side handshake bundle of the capture buffer.
// Revision : 1.0
// =============================================================================
interface operand_wkup_buf_if #(
    parameter int REG_COUNT     = 2,
    parameter int WKUP_COUNT    = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int PAYLOAD_WIDTH = 64
);
    logic                                   in_valid_i;
    logic                                   in_ready_o;
    logic [REG_COUNT-1:0][DATA_WIDTH-1:0]   data_i;
    logic [PAYLOAD_WIDTH-1:0]               payload_i;
    logic [REG_COUNT-1:0][WKUP_COUNT-1:0]   wkup_hit_q_i;
    logic [WKUP_COUNT-1:0][DATA_WIDTH-1:0]  wkup_data_i;
    logic                                   out_valid_o;
    logic                                   out_ready_i;
    logic [REG_COUNT-1:0][DATA_WIDTH-1:0]   real_data_o;
    logic [PAYLOAD_WIDTH-1:0]               payload_o;
    logic                                   wkup_err_o;

    modport slave (
        input  in_valid_i, data_i, payload_i, wkup_hit_q_i, wkup_data_i, out_ready_i,
        output in_ready_o, out_valid_o, real_data_o, payload_o, wkup_err_o
    );

    modport master (
        output in_valid_i, data_i, payload_i, wkup_hit_q_i, wkup_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, real_data_o, payload_o, wkup_err_o
    );

endinterface : operand_wkup_buf_if
`default_nettype wire

// File: rtl/operand_wkup_buf_wkup_merge.sv
`default_nettype none
// =============================================================================
// Module   : wkup_merge
// Brief    : Per-operand selector between stale issue data and wake-up data.
//            WKUP_MULTIHIT_CHK_EN: lowest channel wins, multi-hit is flagged.
// Revision : 1.0
// =============================================================================
module wkup_merge
    import operand_wkup_buf_pkg::*;
#(
    parameter int WKUP_COUNT = 2,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic [WKUP_COUNT-1:0]                 hit_i,
    input  wire logic [WKUP_COUNT-1:0][DATA_WIDTH-1:0] wkup_data_i,
    input  wire logic [DATA_WIDTH-1:0]                 stale_i,
    output logic      [DATA_WIDTH-1:0]                 data_o,
    output logic                                       multi_hit_o
);

`ifdef WKUP_MULTIHIT_CHK_EN
    logic w_found;

    always_comb begin
        data_o      = stale_i;
        multi_hit_o = 1'b0;
        w_found     = 1'b0;
        for (int j = 0; j < WKUP_COUNT; j++) begin
            if (hit_i[j]) begin
                if (w_found) begin
                    multi_hit_o = 1'b1;
                end else begin
                    data_o  = wkup_data_i[j];
                    w_found = 1'b1;
                end
            end
        end
    end
`else
    logic [DATA_WIDTH-1:0] w_or;

    always_comb begin
        w_or = '0;
        for (int j = 0; j < WKUP_COUNT; j++) begin
            if (hit_i[j]) begin
                w_or = w_or | wkup_data_i[j];
            end
        end
        data_o = (|hit_i) ? w_or : stale_i;
    end

    assign multi_hit_o = 1'b0;
`endif

endmodule : wkup_merge
`default_nettype wire

// File: rtl/operand_wkup_buf.sv
`default_nettype none
// =============================================================================
// Module   : operand_wkup_buf
// Brief    : Single-entry operand capture buffer merging next-cycle wake-up data
//            and holding it under back-pressure. Option: WKUP_MULTIHIT_CHK_EN.
// Revision : 1.0
// =============================================================================
module operand_wkup_buf
    import operand_wkup_buf_pkg::*;
#(
    parameter int REG_COUNT     = 2,
    parameter int WKUP_COUNT    = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int PAYLOAD_WIDTH = 64
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         flush,
    operand_wkup_buf_if.slave bus
);

    buf_state_e                           state_q, state_d;
    logic [REG_COUNT-1:0][DATA_WIDTH-1:0] data_q, data_d;
    logic [REG_COUNT-1:0][WKUP_COUNT-1:0] hit_q, hit_d;
    logic [PAYLOAD_WIDTH-1:0]             payload_q, payload_d;

    logic [REG_COUNT-1:0][DATA_WIDTH-1:0] w_real;
    logic [REG_COUNT-1:0]                 w_multi;
    logic                                 w_in_ready;
    logic                                 w_accept;

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_merge
        wkup_merge #(
            .WKUP_COUNT (WKUP_COUNT),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_wkup_merge (
            .hit_i       (hit_q[g]),
            .wkup_data_i (bus.wkup_data_i),
            .stale_i     (data_q[g]),
            .data_o      (w_real[g]),
            .multi_hit_o (w_multi[g])
        );
    end

    assign w_in_ready = (state_q == EMPTY) | bus.out_ready_i;
    assign w_accept   = bus.in_valid_i & w_in_ready & ~flush;

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = (state_q != EMPTY);
    assign bus.real_data_o = w_real;
    assign bus.payload_o   = payload_q;
    assign bus.wkup_err_o  = (state_q == FRESH) & (|w_multi);

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        hit_d     = hit_q;
        payload_d = payload_q;

        if (flush) begin
            state_d = EMPTY;
            hit_d   = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (w_accept) begin
                        state_d   = FRESH;
                        data_d    = bus.data_i;
                        hit_d     = bus.wkup_hit_q_i;
                        payload_d = bus.payload_i;
                    end
                end
                FRESH, HELD: begin
                    if (bus.out_ready_i) begin
                        // Clearing hits on the way out keeps EMPTY output free of wake-up traffic.
                        state_d = EMPTY;
                        hit_d   = '0;
                        if (w_accept) begin
                            state_d   = FRESH;
                            data_d    = bus.data_i;
                            hit_d     = bus.wkup_hit_q_i;
                            payload_d = bus.payload_i;
                        end
                    end else if (state_q == FRESH) begin
                        state_d = HELD;
                        data_d  = w_real;
                        hit_d   = '0;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    hit_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            data_q    <= '0;
            hit_q     <= '0;
            payload_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            hit_q     <= hit_d;
            payload_q <= payload_d;
        end
    end

endmodule : operand_wkup_buf
`default_nettype wire

// File: tb/tb_operand_wkup_buf.sv
`default_nettype none
// =============================================================================
// Module   : tb_operand_wkup_buf
// Brief    : Randomized scoreboard bench for operand_wkup_buf with directed cases.
// Revision : 1.0
// =============================================================================
module tb_operand_wkup_buf;

    localparam int RC = 2;
    localparam int WC = 2;
    localparam int DW = 32;
    localparam int PW = 64;

    typedef struct {
        logic [RC*DW-1:0] data;
        logic [PW-1:0]    pay;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    operand_wkup_buf_if #(
        .REG_COUNT(RC), .WKUP_COUNT(WC), .DATA_WIDTH(DW), .PAYLOAD_WIDTH(PW)
    ) bus ();

    operand_wkup_buf #(
        .REG_COUNT(RC), .WKUP_COUNT(WC), .DATA_WIDTH(DW), .PAYLOAD_WIDTH(PW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    logic exp_err = 1'b0;

    // Reference: an instruction is a record; merge happens once, in the cycle after accept.
    bit               m_occ    = 0;
    bit               m_merged = 0;
    logic [RC*DW-1:0] m_data;
    logic [RC*WC-1:0] m_hits;
    logic [PW-1:0]    m_pay;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void ref_merge(input logic [RC*DW-1:0] stale, input logic [RC*WC-1:0] hits,
                                      input logic [WC*DW-1:0] wk,
                                      output logic [RC*DW-1:0] res, output logic err);
        err = 1'b0;
        for (int i = 0; i < RC; i++) begin
            int n;
            logic [DW-1:0] acc;
            n   = 0;
            acc = '0;
            for (int j = 0; j < WC; j++) begin
                if (hits[i*WC+j]) begin
                    n++;
`ifdef WKUP_MULTIHIT_CHK_EN
                    if (n == 1) acc = wk[j*DW +: DW];
`else
                    acc = acc | wk[j*DW +: DW];
`endif
                end
            end
            res[i*DW +: DW] = (n > 0) ? acc : stale[i*DW +: DW];
`ifdef WKUP_MULTIHIT_CHK_EN
            if (n > 1) err = 1'b1;
`endif
        end
    endfunction

    always @(negedge clk) begin : p_model
        logic [RC*DW-1:0] res;
        logic             e;
        bit               acc;
        if (!rst_n) begin
            m_occ   = 0;
            m_merged = 0;
            exp_err = 1'b0;
        end else begin
            exp_err = 1'b0;
            if (m_occ && !m_merged) begin
                ref_merge(m_data, m_hits, bus.wkup_data_i, res, e);
                exp_q.push_back('{data: res, pay: m_pay});
                m_merged = 1;
                exp_err  = e;
            end
            if (flush) begin
                m_occ = 0;
            end else begin
                acc = bus.in_valid_i && (!m_occ || bus.out_ready_i);
                if (m_occ && bus.out_ready_i) m_occ = 0;
                if (acc) begin
                    m_occ    = 1;
                    m_merged = 0;
                    m_data   = bus.data_i;
                    m_hits   = bus.wkup_hit_q_i;
                    m_pay    = bus.payload_i;
                end
            end
        end
    end

    always @(negedge clk) begin : p_monitor
        bit ev;
        #1;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            ev = (exp_q.size() != 0);
            chk("out_valid", 128'(bus.out_valid_o), 128'(ev));
            chk("in_ready", 128'(bus.in_ready_o), 128'(!ev || bus.out_ready_i));
            chk("wkup_err", 128'(bus.wkup_err_o), 128'(exp_err));
            if (ev && bus.out_valid_o) begin
                chk("real_data", 128'(bus.real_data_o), 128'(exp_q[0].data));
                chk("payload", 128'(bus.payload_o), 128'(exp_q[0].pay));
            end
            if (flush) exp_q.delete();
            else if (ev && bus.out_ready_i) void'(exp_q.pop_front());
        end
    end

    task automatic drv(input logic v, input logic [RC*DW-1:0] d, input logic [RC*WC-1:0] h,
                       input logic [PW-1:0] p, input logic ordy, input logic fl,
                       input logic [WC*DW-1:0] wk);
        bus.in_valid_i   = v;
        bus.data_i       = d;
        bus.wkup_hit_q_i = h;
        bus.payload_i    = p;
        bus.out_ready_i  = ordy;
        flush            = fl;
        bus.wkup_data_i  = wk;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WC*DW-1:0] rwk();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [RC*WC-1:0] rhits();
        logic [RC*WC-1:0] h;
        for (int b = 0; b < RC*WC; b++) h[b] = ($urandom_range(3) == 0);
        return h;
    endfunction

    initial begin
        bus.in_valid_i   = 1'b0;
        bus.data_i       = '0;
        bus.payload_i    = '0;
        bus.wkup_hit_q_i = '0;
        bus.wkup_data_i  = '0;
        bus.out_ready_i  = 1'b0;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 128'(bus.out_valid_o), 128'(0));
        chk("rst_in_ready", 128'(bus.in_ready_o), 128'(1));
        chk("rst_real_data", 128'(bus.real_data_o), 128'(0));
        chk("rst_payload", 128'(bus.payload_o), 128'(0));
        chk("rst_wkup_err", 128'(bus.wkup_err_o), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Plain pass-through, consumed immediately.
        drv(1, {32'h22, 32'h11}, '0, 64'hA1, 1, 0, rwk());
        drv(0, '0, '0, '0, 1, 0, rwk());
        drv(0, '0, '0, '0, 1, 0, rwk());

        // Late wake-up on operand 0 from channel 1, then held under back-pressure.
        drv(1, {32'h5555, 32'h7777}, 4'b0010, 64'hB2, 0, 0, rwk());
        drv(0, '0, '0, '0, 0, 0, {32'hAB, $urandom()});
        repeat (3) drv(1, {$urandom(), $urandom()}, '0, 64'hDEAD, 0, 0, rwk());
        drv(0, '0, '0, '0, 1, 0, rwk());

        // Back-to-back stream.
        for (int k = 0; k < 8; k++)
            drv(1, {$urandom(), $urandom()}, '0, 64'(k + 100), 1, 0, rwk());
        drv(0, '0, '0, '0, 1, 0, rwk());

        // Flush in HELD together with a new instruction.
        drv(1, {32'h1, 32'h2}, '0, 64'hC3, 0, 0, rwk());
        drv(0, '0, '0, '0, 0, 0, rwk());
        drv(1, {32'h3, 32'h4}, '0, 64'hC4, 0, 1, rwk());
        drv(0, '0, '0, '0, 1, 0, rwk());
        drv(0, '0, '0, '0, 1, 0, rwk());

        // Multi-hit on operand 1.
        drv(1, {32'h9, 32'h8}, 4'b1100, 64'hD5, 0, 0, rwk());
        drv(0, '0, '0, '0, 1, 0, {32'h0F, 32'hF0});
        drv(0, '0, '0, '0, 1, 0, rwk());

        // Asynchronous reset while FRESH.
        drv(1, {32'hCAFE, 32'hBEEF}, 4'b0001, 64'hE6, 0, 0, rwk());
        #2;
        bus.in_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(bus.out_valid_o), 128'(0));
        chk("midrst_real_data", 128'(bus.real_data_o), 128'(0));
        chk("midrst_payload", 128'(bus.payload_o), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic.
        repeat (800) begin
            drv($urandom_range(3) != 0, {$urandom(), $urandom()}, rhits(),
                {$urandom(), $urandom()}, $urandom_range(2) != 0,
                $urandom_range(15) == 0, rwk());
        end
        repeat (3) drv(0, '0, '0, '0, 1, 0, rwk());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_operand_wkup_buf
`default_nettype wire
